// File: rtl/ram1p1rwbe_clr.sv
// ram1p1rwbe_clr
//   Single-port read/write SRAM model with byte write enables, a selectable
//   read-during-write behaviour, an optional output register and a built-in
//   clear sequencer that fills every word with CLEAR_VAL after reset or on
//   request. Storage is a behavioural array.
//
// Parameters
//   DEPTH      number of words (power of two, >= 2)
//   WIDTH      bits per word; the top byte lane is partial when WIDTH%8 != 0
//   RDMODE     0 = read-first (old word returned on write),
//              1 = write-first (merged new word returned on write)
//   OUTREG     1 = extra output register, read latency 2 instead of 1
//   CLEAR_VAL  value written to every word by the clear sweep
//
// Ports
//   clk     clock
//   reset   synchronous, active-high reset; restarts the clear sweep
//   ce      access enable (ignored while busy)
//   we      write enable, qualified by ce
//   bwe     byte lane enables, lane i covers bits [8i+7:8i]
//   addr    word address
//   din     write data
//   clr     one-cycle request to clear the whole array
//   busy    clear sweep in progress, accesses are dropped
//   rvalid  dout carries data for an accepted access
//   dout    read data, held while no access returns
module ram1p1rwbe_clr #(
    parameter int              DEPTH     = 64,
    parameter int              WIDTH     = 44,
    parameter int              RDMODE    = 0,
    parameter int              OUTREG    = 0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce,
    input  logic                     we,
    input  logic [(WIDTH-1)/8:0]     bwe,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     clr,
    output logic                     busy,
    output logic                     rvalid,
    output logic [WIDTH-1:0]         dout
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             busy_s;
    logic             accept_s;
    logic             wr_en_s;
    logic [AW-1:0]    wr_addr_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [WIDTH-1:0] lane_mask_s;
    logic [WIDTH-1:0] old_word_s;
    logic [WIDTH-1:0] merged_s;
    logic [WIDTH-1:0] rd_word_s;

    logic             rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0] dout1_q, dout1_d;

    assign busy_s   = (state_q == ST_CLEAR);
    assign accept_s = ce & ~busy_s;

    // Expand byte-lane enables to a per-bit mask; the top lane simply runs out of bits.
    always_comb begin
        lane_mask_s = '0;
        for (int b = 0; b < WIDTH; b++) begin
            lane_mask_s[b] = bwe[b/8];
        end
    end

    // Old word at the access address and the word as it looks after this write.
    always_comb begin
        old_word_s = mem_q[addr];
        if (we) begin
            merged_s = (old_word_s & ~lane_mask_s) | (din & lane_mask_s);
        end else begin
            merged_s = old_word_s;
        end
        if (RDMODE == 1) begin
            rd_word_s = merged_s;
        end else begin
            rd_word_s = old_word_s;
        end
    end

    // Clear sequencer and write-port steering.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_en_s   = 1'b0;
        wr_addr_s = addr;
        wr_data_s = merged_s;
        case (state_q)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = ptr_q;
                wr_data_s = CLEAR_VAL;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_CLEAR;
                    ptr_d   = ptr_q + AW'(1);
                end
            end
            ST_READY: begin
                // The access presented together with clr still completes.
                wr_en_s = accept_s & we;
                if (clr) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // First read stage: capture data for accepted accesses, otherwise hold.
    always_comb begin
        rvalid1_d = accept_s;
        if (accept_s) begin
            dout1_d = rd_word_s;
        end else begin
            dout1_d = dout1_q;
        end
    end

    // Array write port; contents are not reset, the sweep overwrites them.
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Control state and first read stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            rvalid1_q <= 1'b0;
            dout1_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rvalid1_q <= rvalid1_d;
            dout1_q   <= dout1_d;
        end
    end

    assign busy = busy_s;

    generate
        if (OUTREG == 1) begin : g_outreg
            logic             rvalid2_q, rvalid2_d;
            logic [WIDTH-1:0] dout2_q, dout2_d;

            // Second read stage follows the first one, holding when nothing returns.
            always_comb begin
                rvalid2_d = rvalid1_q;
                if (rvalid1_q) begin
                    dout2_d = dout1_q;
                end else begin
                    dout2_d = dout2_q;
                end
            end

            // Second read stage registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid2_q <= 1'b0;
                    dout2_q   <= '0;
                end else begin
                    rvalid2_q <= rvalid2_d;
                    dout2_q   <= dout2_d;
                end
            end

            assign rvalid = rvalid2_q;
            assign dout   = dout2_q;
        end else begin : g_noreg
            assign rvalid = rvalid1_q;
            assign dout   = dout1_q;
        end
    endgenerate

endmodule

// File: tb/tb_ram1p1rwbe_clr.sv
// Testbench for ram1p1rwbe_clr. Two instances run in lockstep on the same
// stimulus: dut_a (read-first, no output register, CLEAR_VAL=0) and dut_b
// (write-first, output register, nonzero CLEAR_VAL). Expected read data and
// the cycle it must appear in are queued at issue time; per-instance
// monitors pop and compare whenever rvalid is seen, and check dout holds
// its last value when rvalid is low.
module tb_ram1p1rwbe_clr;

    localparam int DEPTH = 64;
    localparam int WIDTH = 44;
    localparam int NB    = (WIDTH - 1) / 8 + 1;
    localparam int AW    = 6;
    localparam logic [WIDTH-1:0] CV_A = 44'h000_0000_0000;
    localparam logic [WIDTH-1:0] CV_B = 44'h5A5_A5A5_A5A5;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          ce    = 1'b0;
    logic          we    = 1'b0;
    logic          clr   = 1'b0;
    logic [NB-1:0] bwe   = '0;
    logic [AW-1:0] addr  = '0;
    logic [WIDTH-1:0] din = '0;

    logic             busy_a, rvalid_a, busy_b, rvalid_b;
    logic [WIDTH-1:0] dout_a, dout_b;

    ram1p1rwbe_clr #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RDMODE(0), .OUTREG(0), .CLEAR_VAL(CV_A)) dut_a (
        .clk(clk), .reset(reset), .ce(ce), .we(we), .bwe(bwe), .addr(addr), .din(din),
        .clr(clr), .busy(busy_a), .rvalid(rvalid_a), .dout(dout_a));

    ram1p1rwbe_clr #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RDMODE(1), .OUTREG(1), .CLEAR_VAL(CV_B)) dut_b (
        .clk(clk), .reset(reset), .ce(ce), .we(we), .bwe(bwe), .addr(addr), .din(din),
        .clr(clr), .busy(busy_b), .rvalid(rvalid_b), .dout(dout_b));

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_prev = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    typedef struct {
        logic [WIDTH-1:0] data;
        int               when;
    } exp_t;

    exp_t             q_a[$];
    exp_t             q_b[$];
    logic [WIDTH-1:0] mdl_a [DEPTH];
    logic [WIDTH-1:0] mdl_b [DEPTH];
    int               tests  = 0;
    int               fails  = 0;
    bit               mon_en = 1'b0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference byte-lane merge, written bit by bit.
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old, input logic [WIDTH-1:0] d,
                                               input logic [NB-1:0] be, input logic w);
        merge = old;
        if (w) begin
            for (int l = 0; l < NB; l++) begin
                if (be[l]) begin
                    for (int b = 8 * l; b < 8 * l + 8; b++) begin
                        if (b < WIDTH) merge[b] = d[b];
                    end
                end
            end
        end
    endfunction

    // Monitor for dut_a.
    logic [WIDTH-1:0] last_a;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_prev) last_a = '0;
            if (rvalid_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_rvalid_a: got rvalid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q_a.pop_front();
                    check("rdata_a", dout_a, e.data);
                    check_int("latency_a", cyc, e.when);
                    last_a = e.data;
                end
            end else begin
                check("hold_a", dout_a, last_a);
            end
        end
    end

    // Monitor for dut_b.
    logic [WIDTH-1:0] last_b;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_prev) last_b = '0;
            if (rvalid_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_rvalid_b: got rvalid=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q_b.pop_front();
                    check("rdata_b", dout_b, e.data);
                    check_int("latency_b", cyc, e.when);
                    last_b = e.data;
                end
            end else begin
                check("hold_b", dout_b, last_b);
            end
        end
    end

    // One accepted access; called just after a rising edge, returns just after the next.
    task automatic access(input logic w, input logic [NB-1:0] be, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic c);
        exp_t             e;
        logic [WIDTH-1:0] old;
        ce = 1'b1; we = w; bwe = be; addr = a; din = d; clr = c;
        old = mdl_a[a];
        mdl_a[a] = merge(old, d, be, w);
        e.data = old;       e.when = cyc + 1; q_a.push_back(e);
        old = mdl_b[a];
        mdl_b[a] = merge(old, d, be, w);
        e.data = mdl_b[a];  e.when = cyc + 2; q_b.push_back(e);
        if (c) begin
            for (int i = 0; i < DEPTH; i++) begin
                mdl_a[i] = CV_A;
                mdl_b[i] = CV_B;
            end
        end
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        ce = 1'b0; we = 1'b0; clr = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Count busy cycles from now on; optionally pulse clr at busy cycle clr_at.
    task automatic wait_sweep(input string name, input int clr_at, input int expect_n);
        int n = 0;
        while (busy_a === 1'b1 && n < 200) begin
            clr = (n == clr_at);
            n++;
            @(posedge clk); #1;
        end
        ce = 1'b0; we = 1'b0; clr = 1'b0;
        check_int(name, n, expect_n);
        check_int({name, "_b"}, int'(busy_b), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with an access held active; all of it must be ignored while busy.
        reset = 1'b1; ce = 1'b1; we = 1'b1; bwe = '1; addr = 6'd7; din = 44'hFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check_int("busy_in_reset", int'(busy_a), 1);
        reset = 1'b0;
        wait_sweep("t1_busy_len", -1, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            mdl_a[i] = CV_A;
            mdl_b[i] = CV_B;
        end
        access(1'b0, 6'h00, 6'd0,  44'h0, 1'b0);
        access(1'b0, 6'h00, 6'd17, 44'h0, 1'b0);
        access(1'b0, 6'h00, 6'd63, 44'h0, 1'b0);
        access(1'b0, 6'h00, 6'd7,  44'h0, 1'b0);
        idle(3);

        // T2: partial write of lanes 0 and 5 (lane 5 is the 4-bit top lane).
        access(1'b1, 6'b100001, 6'd5, 44'hABC_DEF0_1234, 1'b0);
        access(1'b0, 6'h00, 6'd5, 44'h0, 1'b0);
        idle(3);
        check("t2_word_a", dout_a, 44'hA00_0000_0034);
        check("t2_word_b", dout_b, 44'hAA5_A5A5_A534);
        // we=1 with no lanes enabled behaves as a read
        access(1'b1, 6'h00, 6'd5, 44'h123_4567_89AB, 1'b0);
        idle(3);

        // T3: read-during-write, then a plain read.
        access(1'b1, 6'h3F, 6'd9, 44'h11, 1'b0);
        access(1'b1, 6'h3F, 6'd9, 44'h22, 1'b0);
        idle(3);
        check("t3_rdw_a", dout_a, 44'h11);
        check("t3_rdw_b", dout_b, 44'h22);
        access(1'b0, 6'h00, 6'd9, 44'h0, 1'b0);
        idle(3);
        check("t3_read_a", dout_a, 44'h22);

        // T4: back-to-back reads then idle with held output.
        access(1'b1, 6'h3F, 6'd1, 44'h111_0000_0001, 1'b0);
        access(1'b1, 6'h3F, 6'd2, 44'h222_0000_0002, 1'b0);
        access(1'b1, 6'h3F, 6'd3, 44'h333_0000_0003, 1'b0);
        access(1'b0, 6'h00, 6'd1, 44'h0, 1'b0);
        access(1'b0, 6'h00, 6'd2, 44'h0, 1'b0);
        access(1'b0, 6'h00, 6'd3, 44'h0, 1'b0);
        idle(4);
        check("t4_hold_b", dout_b, 44'h333_0000_0003);
        // write followed immediately by read of the same word
        access(1'b1, 6'b000010, 6'd3, 44'h000_0000_AB00, 1'b0);
        access(1'b0, 6'h00, 6'd3, 44'h0, 1'b0);
        idle(3);
        check("t4_rmw_a", dout_a, 44'h333_0000_AB03);

        // T5: fill, clear together with a write, extra clr mid-sweep.
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, 6'h3F, AW'(i), 44'h123_4567_0000 + 44'(i), 1'b0);
        end
        access(1'b1, 6'h3F, 6'd4, 44'hBEE_F000_0004, 1'b1);
        wait_sweep("t5_busy_len", 20, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 6'h00, AW'(i), 44'h0, 1'b0);
        end
        idle(3);

        // T6: reset in the middle of a sweep restarts it.
        access(1'b1, 6'h3F, 6'd10, 44'hDEA_DBEE_F010, 1'b0);
        idle(2);
        clr = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_a[i] = CV_A;
            mdl_b[i] = CV_B;
        end
        @(posedge clk); #1;
        clr = 1'b0;
        idle(30);
        check_int("t6_busy_mid", int'(busy_a), 1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        wait_sweep("t6_busy_len", -1, DEPTH);
        access(1'b0, 6'h00, 6'd10, 44'h0, 1'b0);
        access(1'b0, 6'h00, 6'd63, 44'h0, 1'b0);
        idle(5);

        check_int("q_a_drained", q_a.size(), 0);
        check_int("q_b_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
